// File: rtl/sha_block_padder_if.sv
// Stream bundle for the SHA block padder: message beats in, padded blocks out.
// The slave modport is the padder's view; master is the view of whoever
// feeds the message and consumes the blocks.
interface sha_block_padder_if #(
  parameter int DATA_W = 512
) ();
  localparam int KEEP_W = DATA_W / 8;

  // Message input stream
  logic              o_tready_in;
  logic              i_tvalid_in;
  logic [DATA_W-1:0] i_tdata_in;
  logic [KEEP_W-1:0] i_tkeep_in;
  logic              i_tlast_in;

  // Padded block output stream
  logic              i_tready_out;
  logic              o_tvalid_out;
  logic [DATA_W-1:0] o_tdata_out;
  logic              o_tlast_out;

  modport slave (
    output o_tready_in,
    input  i_tvalid_in,
    input  i_tdata_in,
    input  i_tkeep_in,
    input  i_tlast_in,
    input  i_tready_out,
    output o_tvalid_out,
    output o_tdata_out,
    output o_tlast_out
  );

  modport master (
    input  o_tready_in,
    output i_tvalid_in,
    output i_tdata_in,
    output i_tkeep_in,
    output i_tlast_in,
    output i_tready_out,
    input  o_tvalid_out,
    input  o_tdata_out,
    input  o_tlast_out
  );
endinterface

// File: rtl/sha_block_padder.sv
// SHA-1/SHA-2 message padder. Full beats pass straight through; the last beat
// is closed with 0x80, zero fill and the big-endian bit length. When the
// length does not fit behind the tail bytes, a second (EXTRA) block is
// emitted and input is stalled for that one block.
module sha_block_padder #(
  parameter int DATA_W = 512,
  parameter int LEN_W  = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  sha_block_padder_if.slave     bus,
  output logic                  o_err
);
  localparam int KEEP_W = DATA_W / 8;
  localparam int L      = LEN_W / 8;

  typedef enum logic {PASS, EXTRA} state_e;

  state_e            state_q;
  logic              tvalid_q;
  logic              tlast_q;
  logic [DATA_W-1:0] tdata_q;
  logic [LEN_W-1:0]  len_q;       // bits seen so far in the current message
  logic              extra80_q;   // EXTRA block must carry the 0x80 marker
  logic              err_q;

  logic              load_ok;
  logic              accept;
  logic [31:0]       r_cnt;
  logic [KEEP_W-1:0] contig_mask;
  logic              keep_bad;
  logic              fits;
  logic [LEN_W-1:0]  len_total_d;
  logic [DATA_W-1:0] last_blk_d;
  logic [DATA_W-1:0] extra_blk_d;

  assign load_ok         = !tvalid_q || bus.i_tready_out;
  assign bus.o_tready_in = load_ok && (state_q == PASS);
  assign accept          = bus.i_tvalid_in && bus.o_tready_in;

  assign bus.o_tvalid_out = tvalid_q;
  assign bus.o_tdata_out  = tdata_q;
  assign bus.o_tlast_out  = tlast_q;
  assign o_err            = err_q;

  // Decode the current beat: byte count, keep legality and the closing blocks.
  always_comb begin
    // NOTE: every variable gets a default before any conditional assignment,
    // so no path leaves it unassigned and no latch is inferred.
    r_cnt       = '0;
    last_blk_d  = '0;
    extra_blk_d = '0;
    for (int i = 0; i < KEEP_W; i++) begin
      r_cnt = r_cnt + 32'(bus.i_tkeep_in[i]);
    end
    // Legal keep is r ones packed against the MSB byte.
    contig_mask = ~({KEEP_W{1'b1}} >> r_cnt);
    keep_bad    = (bus.i_tkeep_in != contig_mask) ||
                  (!bus.i_tlast_in && (r_cnt != 32'(KEEP_W)));
    len_total_d = len_q + LEN_W'(r_cnt << 3);
    fits        = r_cnt <= 32'(KEEP_W - L - 1);

    for (int i = 0; i < KEEP_W; i++) begin
      if (32'(i) < r_cnt) begin
        if (bus.i_tkeep_in[KEEP_W-1-i]) begin
          last_blk_d[DATA_W-1-8*i -: 8] = bus.i_tdata_in[DATA_W-1-8*i -: 8];
        end
      end else if (32'(i) == r_cnt) begin
        last_blk_d[DATA_W-1-8*i -: 8] = 8'h80;
      end
    end
    if (fits) begin
      last_blk_d[LEN_W-1:0] = len_total_d;
    end

    extra_blk_d[DATA_W-1 -: 8] = extra80_q ? 8'h80 : 8'h00;
    extra_blk_d[LEN_W-1:0]     = len_q;
  end

  // PASS/EXTRA control, output register stage, length counter and error flag.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    if (!reset_n) begin
      state_q   <= PASS;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      tdata_q   <= '0;
      len_q     <= '0;
      extra80_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (accept && keep_bad) begin
        err_q <= 1'b1;
      end
      if (state_q == PASS) begin
        if (accept) begin
          tvalid_q <= 1'b1;
          if (!bus.i_tlast_in) begin
            tdata_q <= bus.i_tdata_in;
            tlast_q <= 1'b0;
            len_q   <= len_total_d;
          end else begin
            tdata_q   <= last_blk_d;
            tlast_q   <= fits;
            extra80_q <= (r_cnt == 32'(KEEP_W));
            if (fits) begin
              len_q <= '0;
            end else begin
              len_q   <= len_total_d;
              state_q <= EXTRA;
            end
          end
        end else if (bus.i_tready_out) begin
          tvalid_q <= 1'b0;
        end
      end else if (load_ok) begin
        tvalid_q <= 1'b1;
        tdata_q  <= extra_blk_d;
        tlast_q  <= 1'b1;
        len_q    <= '0;
        state_q  <= PASS;
      end
    end
  end
endmodule

// File: tb/tb_sha_block_padder.sv
// Bench for sha_block_padder: one 512/64 and one 1024/128 instance. Expected
// blocks come from textbook SHA padding of the whole message, cut into blocks.
module tb_sha_block_padder;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  sha_block_padder_if #(.DATA_W(512))  bus_a ();
  sha_block_padder_if #(.DATA_W(1024)) bus_b ();
  logic err_a, err_b;

  sha_block_padder #(.DATA_W(512), .LEN_W(64)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(bus_a), .o_err(err_a));
  sha_block_padder #(.DATA_W(1024), .LEN_W(128)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(bus_b), .o_err(err_b));

  typedef logic [7:0] bytes_t[$];
  typedef struct {
    logic [1023:0] d;
    logic          l;
  } blk_t;
  typedef blk_t blk_q_t[$];

  blk_t exp_a[$];
  blk_t exp_b[$];
  int   n_total = 0;
  int   n_bad   = 0;
  int   mode_a  = 0;   // 0 ready, 1 random, 2 toggle, 3 stalled
  int   mode_b  = 0;
  int   gap_max = 0;

  logic          hold[2];
  logic [1023:0] hd[2];
  logic          hl[2];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic check_blk(input string name, input logic [1023:0] act, input logic [1023:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      for (int k = 127; k >= 0; k--) begin
        if (act[8*k +: 8] !== exp[8*k +: 8]) begin
          $display("FAIL %s: byte at bit %0d got %h want %h (low 64b got %h want %h)",
                   name, 8*k, act[8*k +: 8], exp[8*k +: 8], act[63:0], exp[63:0]);
          break;
        end
      end
    end
  endtask

  // Reference: msg || 0x80 || zeros || bit length, cut into kw-byte blocks.
  task automatic pad(input bytes_t msg, input int kw, input int lb, output blk_q_t blks);
    bytes_t        p;
    logic [127:0]  bl;
    blk_t          b;
    int            nb;
    p  = msg;
    bl = 128'(msg.size()) << 3;
    p.push_back(8'h80);
    while (((p.size() + lb) % kw) != 0) p.push_back(8'h00);
    for (int j = lb - 1; j >= 0; j--) p.push_back(bl[8*j +: 8]);
    nb   = p.size() / kw;
    blks = {};
    for (int bi = 0; bi < nb; bi++) begin
      b.d = '0;
      for (int i = 0; i < kw; i++) b.d[kw*8-1-8*i -: 8] = p[bi*kw + i];
      b.l = (bi == nb - 1);
      blks.push_back(b);
    end
  endtask

  // Downstream ready generators, updated just after each rising edge.
  initial begin
    bus_a.i_tready_out = 1'b1;
    bus_b.i_tready_out = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (mode_a)
        0:       bus_a.i_tready_out = 1'b1;
        1:       bus_a.i_tready_out = 1'($urandom_range(0, 1));
        2:       bus_a.i_tready_out = !bus_a.i_tready_out;
        default: bus_a.i_tready_out = 1'b0;
      endcase
      case (mode_b)
        0:       bus_b.i_tready_out = 1'b1;
        1:       bus_b.i_tready_out = 1'($urandom_range(0, 1));
        2:       bus_b.i_tready_out = !bus_b.i_tready_out;
        default: bus_b.i_tready_out = 1'b0;
      endcase
    end
  end

  task automatic cmp_port(input int sel);
    logic          v, l, rdy;
    logic [1023:0] d;
    blk_t          e;
    v   = sel ? bus_b.o_tvalid_out : bus_a.o_tvalid_out;
    l   = sel ? bus_b.o_tlast_out  : bus_a.o_tlast_out;
    rdy = sel ? bus_b.i_tready_out : bus_a.i_tready_out;
    d   = sel ? bus_b.o_tdata_out  : {512'h0, bus_a.o_tdata_out};
    if (hold[sel]) begin
      check(sel ? "b_hold_valid" : "a_hold_valid", 128'(v), 128'd1);
      check_blk(sel ? "b_hold_data" : "a_hold_data", d, hd[sel]);
      check(sel ? "b_hold_last" : "a_hold_last", 128'(l), 128'(hl[sel]));
    end
    if (v && rdy) begin
      if ((sel ? exp_b.size() : exp_a.size()) == 0) begin
        n_total++;
        n_bad++;
        $display("FAIL %s: got an output block, want none", sel ? "b_unexpected" : "a_unexpected");
      end else begin
        e = sel ? exp_b.pop_front() : exp_a.pop_front();
        check_blk(sel ? "b_blk_data" : "a_blk_data", d, e.d);
        check(sel ? "b_blk_last" : "a_blk_last", 128'(l), 128'(e.l));
      end
    end
    hold[sel] = v && !rdy;
    hd[sel]   = d;
    hl[sel]   = l;
  endtask

  // Single compare process: every output handshake and every stall cycle.
  always @(negedge clk) begin
    if (!reset_n) begin
      hold[0] = 1'b0;
      hold[1] = 1'b0;
    end else begin
      cmp_port(0);
      cmp_port(1);
    end
  end

  task automatic drive_beat(input int sel, input logic [1023:0] d, input logic [127:0] k, input logic last);
    int w = 0;
    if (sel != 0) begin
      bus_b.i_tdata_in = d;
      bus_b.i_tkeep_in = k;
      bus_b.i_tlast_in = last;
      bus_b.i_tvalid_in = 1'b1;
    end else begin
      bus_a.i_tdata_in = d[511:0];
      bus_a.i_tkeep_in = k[63:0];
      bus_a.i_tlast_in = last;
      bus_a.i_tvalid_in = 1'b1;
    end
    @(negedge clk);
    while (!(sel != 0 ? bus_b.o_tready_in : bus_a.o_tready_in) && w < 500) begin
      @(negedge clk);
      w++;
    end
    if (w >= 500) begin
      n_total++;
      n_bad++;
      $display("FAIL ready_timeout: o_tready_in held 0 for %0d cycles, want 1", w);
    end
    @(posedge clk);
    #1;
    bus_a.i_tvalid_in = 1'b0;
    bus_b.i_tvalid_in = 1'b0;
  endtask

  // last_mode: 0 random, 1 full last beat, 2 empty last beat (when len % kw == 0)
  task automatic send_msg(input int sel, input bytes_t msg, input int last_mode);
    int            kw, lb, n, full, r;
    blk_q_t        blks;
    logic [1023:0] dd;
    logic [127:0]  kk;
    kw = sel != 0 ? 128 : 64;
    lb = sel != 0 ? 16 : 8;
    pad(msg, kw, lb, blks);
    foreach (blks[i]) begin
      if (sel != 0) exp_b.push_back(blks[i]);
      else          exp_a.push_back(blks[i]);
    end
    n    = msg.size();
    full = n / kw;
    r    = n % kw;
    if (r == 0 && n > 0) begin
      if (!(last_mode == 2 || (last_mode == 0 && $urandom_range(0, 1) == 1))) begin
        full--;
        r = kw;
      end
    end
    @(posedge clk);
    #1;
    for (int b = 0; b < full; b++) begin
      dd = '0;
      kk = '0;
      for (int i = 0; i < kw; i++) begin
        dd[kw*8-1-8*i -: 8] = msg[b*kw + i];
        kk[i] = 1'b1;
      end
      drive_beat(sel, dd, kk, 1'b0);
      repeat ($urandom_range(0, gap_max)) begin
        @(posedge clk);
        #1;
      end
    end
    dd = '0;
    kk = '0;
    for (int i = 0; i < kw; i++) begin
      dd[kw*8-1-8*i -: 8] = (i < r) ? msg[full*kw + i] : 8'($urandom);
      if (i < r) kk[kw-1-i] = 1'b1;
    end
    drive_beat(sel, dd, kk, 1'b1);
  endtask

  task automatic drain(input int sel);
    int w = 0;
    while ((sel != 0 ? exp_b.size() : exp_a.size()) != 0 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 3000) begin
      n_total++;
      n_bad++;
      $display("FAIL drain_timeout: %0d blocks still pending, want 0",
               sel != 0 ? exp_b.size() : exp_a.size());
    end
  endtask

  function automatic bytes_t rand_msg(input int n);
    bytes_t m;
    m = {};
    for (int i = 0; i < n; i++) m.push_back(8'($urandom));
    return m;
  endfunction

  initial begin
    logic [511:0]  abc_blk;
    logic [511:0]  blk35;
    logic [1023:0] blk36;
    logic [1023:0] dd;
    bytes_t        abc;
    bytes_t        m;
    blk_q_t        bq;
    blk_t          eb;

    abc_blk = {32'h61626380, 416'h0, 64'h18};
    blk35   = {8'h80, 440'h0, 64'h400};
    blk36   = {8'h80, 888'h0, 128'h400};
    abc     = {8'h61, 8'h62, 8'h63};

    bus_a.i_tvalid_in = 1'b0; bus_a.i_tdata_in = '0; bus_a.i_tkeep_in = '0; bus_a.i_tlast_in = 1'b0;
    bus_b.i_tvalid_in = 1'b0; bus_b.i_tdata_in = '0; bus_b.i_tkeep_in = '0; bus_b.i_tlast_in = 1'b0;

    // Pin the reference model with hand-computed blocks.
    pad(abc, 64, 8, bq);
    check("model_abc_count", 128'(bq.size()), 128'd1);
    check_blk("model_abc", bq[0].d, {512'h0, abc_blk});
    pad(rand_msg(55), 64, 8, bq);
    check("model_55_count", 128'(bq.size()), 128'd1);
    check("model_55_marker", 128'(bq[0].d[71:64]), 128'h80);
    check("model_55_len", 128'(bq[0].d[63:0]), 128'h1B8);
    pad(rand_msg(56), 64, 8, bq);
    check("model_56_count", 128'(bq.size()), 128'd2);
    check("model_56_marker", 128'(bq[0].d[63:56]), 128'h80);
    check_blk("model_56_extra", bq[1].d, {960'h0, 64'h1C0});
    pad(rand_msg(128), 64, 8, bq);
    check_blk("model_128_third", bq[2].d, {512'h0, blk35});
    pad(rand_msg(128), 128, 16, bq);
    check_blk("model_1k_extra", bq[1].d, blk36);

    // Reset values while reset is held.
    #12;
    check("rst_a_valid", 128'(bus_a.o_tvalid_out), 128'd0);
    check("rst_a_last", 128'(bus_a.o_tlast_out), 128'd0);
    check("rst_a_data", 128'(bus_a.o_tdata_out[127:0]), 128'd0);
    check("rst_a_err", 128'(err_a), 128'd0);
    check("rst_b_valid", 128'(bus_b.o_tvalid_out), 128'd0);
    check("rst_b_err", 128'(err_b), 128'd0);
    @(negedge clk);
    #2 reset_n = 1'b1;
    #1;
    check("rdy_a_after_rst", 128'(bus_a.o_tready_in), 128'd1);
    check("rdy_b_after_rst", 128'(bus_b.o_tready_in), 128'd1);

    // "abc": one block, one cycle after acceptance.
    send_msg(0, abc, 1);
    @(negedge clk);
    check("abc_valid", 128'(bus_a.o_tvalid_out), 128'd1);
    check("abc_last", 128'(bus_a.o_tlast_out), 128'd1);
    check_blk("abc_data", {512'h0, bus_a.o_tdata_out}, {512'h0, abc_blk});
    drain(0);

    send_msg(0, rand_msg(55), 1);
    drain(0);

    // 56 bytes: EXTRA block follows and input is held off meanwhile.
    send_msg(0, rand_msg(56), 1);
    @(negedge clk);
    check("extra_rdy_low", 128'(bus_a.o_tready_in), 128'd0);
    check("extra_first_last", 128'(bus_a.o_tlast_out), 128'd0);
    @(negedge clk);
    check("extra_rdy_back", 128'(bus_a.o_tready_in), 128'd1);
    check("extra_second_last", 128'(bus_a.o_tlast_out), 128'd1);
    drain(0);

    send_msg(0, rand_msg(128), 2);
    drain(0);

    // Wide configuration with a toggling consumer.
    mode_b = 2;
    send_msg(1, rand_msg(128), 1);
    drain(1);

    // Randomized traffic on both configurations.
    mode_a  = 1;
    mode_b  = 1;
    gap_max = 2;
    for (int t = 0; t < 30; t++) begin
      send_msg(0, rand_msg($urandom_range(0, 200)), 0);
    end
    drain(0);
    for (int t = 0; t < 20; t++) begin
      send_msg(1, rand_msg($urandom_range(0, 300)), 0);
    end
    drain(1);
    gap_max = 0;
    check("err_a_clean", 128'(err_a), 128'd0);
    check("err_b_clean", 128'(err_b), 128'd0);

    // Partial keep on a non-last beat: flagged, forwarded unchanged.
    mode_a = 0;
    @(posedge clk);
    #1;
    dd = '0;
    for (int i = 0; i < 16; i++) dd[32*i +: 32] = $urandom;
    dd[1023:512] = '0;
    eb.d = dd;
    eb.l = 1'b0;
    exp_a.push_back(eb);
    drive_beat(0, dd, {64'h0, 64'hFFFF_FFFF_0000_0000}, 1'b0);
    @(negedge clk);
    check("err_set", 128'(err_a), 128'd1);
    repeat (3) @(negedge clk);
    check("err_sticky", 128'(err_a), 128'd1);
    drain(0);

    // Reset while the EXTRA block is pending, then a fresh "abc".
    mode_a = 3;
    send_msg(0, rand_msg(56), 1);
    @(negedge clk);
    check("pre_rst_valid", 128'(bus_a.o_tvalid_out), 128'd1);
    check("pre_rst_rdy", 128'(bus_a.o_tready_in), 128'd0);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_valid", 128'(bus_a.o_tvalid_out), 128'd0);
    check("async_rst_last", 128'(bus_a.o_tlast_out), 128'd0);
    check("async_rst_data", 128'(bus_a.o_tdata_out[511:384]), 128'd0);
    check("async_rst_err", 128'(err_a), 128'd0);
    exp_a.delete();
    @(negedge clk);
    #2 reset_n = 1'b1;
    #1;
    check("rdy_after_rerst", 128'(bus_a.o_tready_in), 128'd1);
    mode_a = 0;
    send_msg(0, abc, 1);
    @(negedge clk);
    check("abc2_valid", 128'(bus_a.o_tvalid_out), 128'd1);
    check_blk("abc2_data", {512'h0, bus_a.o_tdata_out}, {512'h0, abc_blk});
    drain(0);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, want finished");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/sha_block_padder.md
SHA_BLOCK_PADDER -- requirements
Module: sha_block_padder

Interface
REQ-001 SHALL have parameter DATA_W, default 512, meaning block width in bits; legal values 512 (SHA-1/SHA-256) and 1024 (SHA-384/SHA-512).
REQ-002 SHALL have parameter LEN_W, default 64, meaning message-length field width in bits; legal values 64 and 128.
REQ-003 SHALL derive the localparam KEEP_W = DATA_W/8, the bytes per beat.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 o_tready_in  output  1  input stream ready.
REQ-007 i_tvalid_in  input  1  input beat valid.
REQ-008 i_tdata_in  input  DATA_W  message bytes, big-endian: byte i at bits [DATA_W-1-8i -: 8].
REQ-009 i_tkeep_in  input  KEEP_W  byte enables; bit KEEP_W-1-i qualifies byte i.
REQ-010 i_tlast_in  input  1  final beat of the message.
REQ-011 i_tready_out  input  1  downstream ready.
REQ-012 o_tvalid_out  output  1  padded block valid.
REQ-013 o_tdata_out  output  DATA_W  padded block, same byte order as the input.
REQ-014 o_tlast_out  output  1  final block of the padded message.
REQ-015 o_err  output  1  sticky protocol error: a non-last beat without full keep, or non-contiguous keep; cleared only by reset.

Function
REQ-016 A transfer SHALL occur on a port when valid and ready are both 1 on a rising edge; o_tvalid_out/o_tdata_out/o_tlast_out SHALL hold stable while o_tvalid_out=1 and i_tready_out=0.
REQ-017 Output SHALL be a single register stage: an accepted input beat appears on the output one cycle later; o_tready_in = (!o_tvalid_out | i_tready_out) & (state==PASS).
REQ-018 Non-last beats SHALL have all-ones keep and SHALL be forwarded unchanged with o_tlast_out=0.
REQ-019 Last-beat keep SHALL be contiguous from the MSB byte, with r = popcount in 0..KEEP_W; r=0 means the message ended on the previous beat.
REQ-020 A bit-length counter of LEN_W bits SHALL accumulate 8*popcount(keep) per accepted beat, wrapping modulo 2^LEN_W, and SHALL restart from 0 for the beat following a tlast.
REQ-021 On the last beat, with L = LEN_W/8: the output block SHALL have bytes 0..r-1 = data, byte r = 0x80 (if r<KEEP_W), and zeros elsewhere; masked input bytes SHALL be forced to 0.
REQ-022 If r <= KEEP_W-L-1, the length SHALL be written big-endian into the final L bytes of that block, with o_tlast_out=1 and the FSM remaining in PASS.
REQ-023 Otherwise, that block SHALL carry o_tlast_out=0 and the FSM SHALL enter EXTRA; o_tready_in=0 while in EXTRA.
REQ-024 The EXTRA block SHALL be all zeros except byte 0 = 0x80 when r=KEEP_W, plus the length in the final L bytes; o_tlast_out=1.
REQ-025 The FSM SHALL return from EXTRA to PASS when the EXTRA block is loaded into the output register; input acceptance SHALL resume on the next cycle once the output register can be reloaded.
REQ-026 An r=0 last beat SHALL produce one block of 0x80 followed by zeros and the length.
REQ-027 o_err SHALL be set when an offending beat is accepted; that beat is still processed as specified, with no recovery attempted.
REQ-028 The FSM SHALL have exactly two states: PASS and EXTRA.

Reset
REQ-029 Asserting reset_n low SHALL immediately set o_tvalid_out=0, o_tlast_out=0, o_err=0, the length counter to 0 and the state to PASS; o_tdata_out SHALL be set to 0.
REQ-030 Reset mid-message or mid-EXTRA SHALL discard the partial message; the first beat after release starts a new message.
REQ-031 o_tready_in SHALL be 1 in the first cycle after reset release.

Verification (DATA_W=512, LEN_W=64 unless stated)
REQ-032 Input "abc" as one last beat, keep=0xE000_0000_0000_0000 -> one block 0x61626380 followed by zeros ending ...0000_0018, o_tlast_out=1, one cycle after acceptance.
REQ-033 55-byte last beat -> one block: byte 55 = 0x80, final 8 bytes = 0x0000_0000_0000_01B8.
REQ-034 56-byte last beat -> block 1 with byte 56 = 0x80 and o_tlast_out=0; block 2 all zeros plus length 0x1C0 with o_tlast_out=1; o_tready_in=0 during EXTRA.
REQ-035 Two full beats then a 0-byte last beat -> three output blocks; the third is 0x80, zeros, then length 0x400.
REQ-036 DATA_W=1024, LEN_W=128, 128-byte single last beat with i_tready_out toggling 1010... -> data block, then EXTRA block with byte 0 = 0x80 and length 0x400, both held stable while stalled.
REQ-037 reset_n pulsed low during EXTRA, then "abc" -> o_tvalid_out drops asynchronously, and the next output equals the REQ-032 block.
